inv_ps_seq: RTL
===============

Name: inv_ps_seq

Overview:
- Iterative inverse of the ASCON substitution layer; exact inverse of ps.
- Applies the inverse 5-bit S-box column-wise over the 320-bit state, COLS_PER_CYCLE columns per clock.
- Used by the decryption/debug path to undo a substitution layer, and by benches to round-trip check ps.
- Area-light: small sequential engine instead of 64 parallel inverse S-boxes.

Parameters:
- COLS_PER_CYCLE, 8, columns processed per cycle. Legal values: 1, 2, 4, 8, 16, 32, 64. Other values are an elaboration error.

Ports:
- clock_i  input  1  system clock, rising edge
- resetb_i  input  1  asynchronous reset, active-low
- start_i  input  1  launch request, sampled on the rising edge
- state_i  input  type_state (5x64)  state to invert, sampled when a start is accepted
- state_o  output  type_state (5x64)  result; valid from the done_o cycle until the next accepted start
- busy_o  output  1  high while the inversion is in progress
- done_o  output  1  single-cycle pulse when state_o becomes valid

Behaviour:
- Column j consists of bit j of words 0..4. 5-bit index = {x0[j],x1[j],x2[j],x3[j],x4[j]}, x0 is the MSB.
- Inverse S-box, input 0..31 -> output: 20,26,7,13,0,9,14,18,10,6,29,1,25,21,19,30,24,22,11,17,3,5,28,31,23,27,4,8,15,12,16,2.
- The result column is written back to the same bit position j. Words are not permuted.
- Reset (resetb_i low, asynchronous): FSM=IDLE, work register=0, column counter=0, state_o=0, busy_o=0, done_o=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_i=1 loads state_i into the work register, clears the counter and goes to RUN.
  - Otherwise stays in IDLE.
- RUN:
  - Each cycle, the COLS_PER_CYCLE least-significant columns are replaced by their inverse S-box values.
  - All five words are then rotated right by COLS_PER_CYCLE.
  - The counter increments by COLS_PER_CYCLE, modulo 64 (6-bit wrap).
  - On the cycle that processes columns 64-COLS_PER_CYCLE..63, the next state is DONE. After 64/COLS_PER_CYCLE rotations the columns are back in their original positions.
- DONE:
  - done_o=1 for exactly this one cycle.
  - state_o shows the finished result.
  - Next state is IDLE, or RUN if start_i=1 in this cycle (back-to-back run, new state_i loaded).
- Latency: start accepted at edge N; done_o high in cycle N+64/COLS_PER_CYCLE+1. Default is 9 cycles.
- busy_o=1 in RUN only. It is 0 in IDLE and DONE.
- start_i while in RUN is ignored, with no effect on the work register or counter.
- state_o is a registered copy, updated only on entry to DONE. It holds its value through IDLE and the next RUN, and intermediate values never appear on it.
- state_i changing during RUN has no effect.
- Reset asserted mid-RUN aborts immediately. Outputs go to reset values; no done_o pulse is produced.
- Pure combinational S-box lookup plus one register stage. No multicycle paths.

Test Plan:
- Reset, then all-zero state_i with one start pulse: done_o after 9 cycles. state_o = {FFFFFFFFFFFFFFFF, 0, FFFFFFFFFFFFFFFF, 0, 0}, since inv(0)=20=10100b.
- All-ones state_i: state_o = {0, 0, 0, FFFFFFFFFFFFFFFF, 0}, since inv(31)=2.
- Round trip: ps_i = {80400c0600000000, 0001020304050607, 08090a0b0c0d0eff, 0011223344556677, 8899aabbccddeeff}. Feed ps_o into inv_ps_seq; state_o must equal ps_i bit-exactly. Repeat for COLS_PER_CYCLE=1 (latency 65) and 64 (latency 2).
- Protocol:
  - start_i held high for 20 cycles: back-to-back results, done_o pulses every 9 cycles.
  - start pulse during RUN: ignored, done_o count unchanged.
  - busy_o low in DONE.
- Reset at cycle 4 of RUN: all outputs go to 0 asynchronously, no done_o pulse. The next start completes normally with the correct result.
- Random regression: 1000 random states through ps then inv_ps_seq; the output must always equal the original input.

Source files
------------

// File: rtl/inv_ps_seq.sv
// Sequential inverse of the ASCON substitution layer: undoes ps by running the
// inverse 5-bit S-box over COLS_PER_CYCLE state columns per clock.
module inv_ps_seq #(
  parameter int unsigned COLS_PER_CYCLE = 8
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             start_i,
  input  logic [4:0][63:0] state_i,
  output logic [4:0][63:0] state_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned WORD_W = 64;
  localparam int unsigned CNT_W  = 6;
  localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(COLS_PER_CYCLE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - COLS_PER_CYCLE);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4 ||
          COLS_PER_CYCLE == 8 || COLS_PER_CYCLE == 16 || COLS_PER_CYCLE == 32 ||
          COLS_PER_CYCLE == 64)) begin : g_bad_cols
      $error("inv_ps_seq: COLS_PER_CYCLE must be a power of two from 1 to 64");
    end
  endgenerate

  function automatic logic [4:0] inv_sbox(input logic [4:0] x);
    logic [4:0] y;
    case (x)
      5'd0:  y = 5'd20; 5'd1:  y = 5'd26; 5'd2:  y = 5'd7;  5'd3:  y = 5'd13;
      5'd4:  y = 5'd0;  5'd5:  y = 5'd9;  5'd6:  y = 5'd14; 5'd7:  y = 5'd18;
      5'd8:  y = 5'd10; 5'd9:  y = 5'd6;  5'd10: y = 5'd29; 5'd11: y = 5'd1;
      5'd12: y = 5'd25; 5'd13: y = 5'd21; 5'd14: y = 5'd19; 5'd15: y = 5'd30;
      5'd16: y = 5'd24; 5'd17: y = 5'd22; 5'd18: y = 5'd11; 5'd19: y = 5'd17;
      5'd20: y = 5'd3;  5'd21: y = 5'd5;  5'd22: y = 5'd28; 5'd23: y = 5'd31;
      5'd24: y = 5'd23; 5'd25: y = 5'd27; 5'd26: y = 5'd4;  5'd27: y = 5'd8;
      5'd28: y = 5'd15; 5'd29: y = 5'd12; 5'd30: y = 5'd16; default: y = 5'd2;
    endcase
    return y;
  endfunction

  logic [1:0]             fsm_q, fsm_d;
  logic [4:0][63:0]       work_q, work_d;
  logic [4:0][63:0]       subst, round;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [4:0][63:0]       result_d;
  logic                   busy_d, done_d;
  logic [4:0]             col_in, col_out;

  // One RUN step: substitute the low columns, then rotate every word right so
  // the next unprocessed columns land at the bottom.
  always_comb begin
    subst   = work_q;
    round   = '0;
    col_in  = '0;
    col_out = '0;
    for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
      col_in  = {work_q[0][6'(k)], work_q[1][6'(k)], work_q[2][6'(k)],
                 work_q[3][6'(k)], work_q[4][6'(k)]};
      col_out = inv_sbox(col_in);
      subst[0][6'(k)] = col_out[4];
      subst[1][6'(k)] = col_out[3];
      subst[2][6'(k)] = col_out[2];
      subst[3][6'(k)] = col_out[1];
      subst[4][6'(k)] = col_out[0];
    end
    for (int unsigned w = 0; w < 5; w++) begin
      for (int unsigned i = 0; i < WORD_W; i++) begin
        round[3'(w)][6'(i)] = subst[3'(w)][6'(i + COLS_PER_CYCLE)];
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    fsm_d    = fsm_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    result_d = state_o;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (fsm_q)
      IDLE, DONE: begin
        fsm_d = IDLE;
        if (start_i) begin
          work_d = state_i;
          cnt_d  = '0;
          fsm_d  = RUN;
          busy_d = 1'b1;
        end
      end
      RUN: begin
        work_d = round;
        cnt_d  = cnt_q + CNT_STEP;
        busy_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          fsm_d    = DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = round;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q   <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      state_o <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      state_o <= result_d;
      busy_o  <= busy_d;
      done_o  <= done_d;
    end
  end

endmodule
